// File: rtl/rtc_write_seq_pkg.sv
// ----------------------------------------------------------------------------
// rtc_write_seq_pkg
//   Shared definitions for the RTC bus sequencers (write and read side).
//   - FSM state encodings (3-bit binary) of the write sequencer.
//   - Default bus timing constants, shared with the read sequencer so both
//     sides of the multiplexed AD bus use the same setup/strobe/hold timing.
//   - Registered-output bundle type and its decode function. The decode is
//     applied to the *next* state so the output flops line up with the state
//     flops and no input-to-output combinational path exists.
// ----------------------------------------------------------------------------
package rtc_write_seq_pkg;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_A_SETUP  = 3'd1;
   localparam logic [2:0] ST_A_STROBE = 3'd2;
   localparam logic [2:0] ST_A_HOLD   = 3'd3;
   localparam logic [2:0] ST_D_SETUP  = 3'd4;
   localparam logic [2:0] ST_D_STROBE = 3'd5;
   localparam logic [2:0] ST_D_HOLD   = 3'd6;
   localparam logic [2:0] ST_DONE     = 3'd7;

   // Default timing, in clock cycles per phase
   localparam int DEF_SETUP_CYC  = 2;
   localparam int DEF_STROBE_CYC = 4;
   localparam int DEF_HOLD_CYC   = 2;
   localparam int DEF_CNT_W      = 4;

   // Everything that leaves the block, held in one register bank
   typedef struct packed {
      logic       cs;
      logic       ad;
      logic       wr;
      logic       oe;
      logic       busy;
      logic       done;
      logic [7:0] bus;
   } wr_outs_t;

   // Output decode for a given state. The address phase drives the latched
   // address with ad=1, the data phase drives the latched data with ad=0;
   // cs is high in all six bus states so it never dips between phases.
   function automatic wr_outs_t decode_outs(input logic [2:0] st,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
      wr_outs_t o;
      o = '0;
      case (st)
         ST_A_SETUP, ST_A_HOLD: begin
            o.cs   = 1'b1;
            o.ad   = 1'b1;
            o.oe   = 1'b1;
            o.busy = 1'b1;
            o.bus  = addr;
         end
         ST_A_STROBE: begin
            o.cs   = 1'b1;
            o.ad   = 1'b1;
            o.wr   = 1'b1;
            o.oe   = 1'b1;
            o.busy = 1'b1;
            o.bus  = addr;
         end
         ST_D_SETUP, ST_D_HOLD: begin
            o.cs   = 1'b1;
            o.oe   = 1'b1;
            o.busy = 1'b1;
            o.bus  = data;
         end
         ST_D_STROBE: begin
            o.cs   = 1'b1;
            o.wr   = 1'b1;
            o.oe   = 1'b1;
            o.busy = 1'b1;
            o.bus  = data;
         end
         ST_DONE: begin
            o.busy = 1'b1;
            o.done = 1'b1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/rtc_write_seq_phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
//   Loadable down-counter used to time each bus phase. Loading (N-1) on entry
//   to a phase and advancing when zero_o is seen gives a phase of exactly N
//   cycles. The counter parks at zero when not reloaded.
//   Ports:
//     clk         in   system clock
//     reset_n     in   asynchronous active-low reset (counter -> 0)
//     load_i      in   load load_val_i on this edge
//     load_val_i  in   CNT_W-bit value to load
//     zero_o      out  counter currently reads zero
// ----------------------------------------------------------------------------
module phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_write_seq.sv
// ----------------------------------------------------------------------------
// rtc_write_seq
//   Generates one multiplexed address/data write to the external RTC chip:
//   address phase then data phase, each with setup / strobe / hold timing.
//   Strobes are active-high and idle at 0 so the downstream combiner passes
//   the read sequencer's strobes untouched while this block is idle.
//   Ports:
//     clk       in   system clock
//     reset_n   in   asynchronous active-low reset
//     start_wr  in   request a write; only looked at in IDLE
//     wr_addr   in   8-bit RTC register address, latched on accepted start
//     wr_data   in   8-bit data byte, latched on accepted start
//     cs_strb   out  chip select (high through both phases)
//     ad_strb   out  1 = address on bus, 0 = data on bus
//     wr_strb   out  write strobe
//     bus_oe    out  this block drives the AD bus
//     bus_out   out  AD bus value
//     busy      out  transaction in progress (all non-IDLE states)
//     done      out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module rtc_write_seq
   import rtc_write_seq_pkg::*;
#(
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int STROBE_CYC = DEF_STROBE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start_wr,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       cs_strb,
   output logic       ad_strb,
   output logic       wr_strb,
   output logic       bus_oe,
   output logic [7:0] bus_out,
   output logic       busy,
   output logic       done
);

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

   logic [2:0]       state_q, state_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   wr_outs_t         outs_q, outs_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // Next-state logic. Every transition into a timed state reloads the timer
   // with that state's length minus one; the state leaves when the timer
   // reads zero.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (start_wr) begin
               state_d  = ST_A_SETUP;
               addr_d   = wr_addr;
               data_d   = wr_data;
               tmr_load = 1'b1;
               tmr_val  = SETUP_LD;
            end
         end
         ST_A_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_A_STROBE;
               tmr_load = 1'b1;
               tmr_val  = STROBE_LD;
            end
         end
         ST_A_STROBE: begin
            if (tmr_zero) begin
               state_d  = ST_A_HOLD;
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end
         end
         ST_A_HOLD: begin
            if (tmr_zero) begin
               state_d  = ST_D_SETUP;
               tmr_load = 1'b1;
               tmr_val  = SETUP_LD;
            end
         end
         ST_D_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_D_STROBE;
               tmr_load = 1'b1;
               tmr_val  = STROBE_LD;
            end
         end
         ST_D_STROBE: begin
            if (tmr_zero) begin
               state_d  = ST_D_HOLD;
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end
         end
         ST_D_HOLD: begin
            if (tmr_zero) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // start_wr is deliberately not looked at here: no queuing
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from the next state and registered, so each pin comes
   // straight off a flop (glitch-free) and changes together with the state.
   always_comb begin
      outs_d = decode_outs(state_d, addr_d, data_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         outs_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         outs_q  <= outs_d;
      end
   end

   assign cs_strb = outs_q.cs;
   assign ad_strb = outs_q.ad;
   assign wr_strb = outs_q.wr;
   assign bus_oe  = outs_q.oe;
   assign bus_out = outs_q.bus;
   assign busy    = outs_q.busy;
   assign done    = outs_q.done;

endmodule
